ff256_pow_engine: RTL and testbench

- Wishbone slave that computes GF(2^8) exponentiation, r = a^e, and multiplicative inverse, a^-1 = a^254.
- Uses MSB-first square-and-multiply, one exponent bit per clock.
- Sits beside the GF(256) multiplier peripheral on the same bus. Software obtains inverses here and feeds them to the multiplier to implement division (e.g. Reed-Solomon/AES flows).
- The field polynomial is a parameter, so it must be set to match the multiplier.

---
 rtl/ff256_pow_engine_if.sv | 26 ++
 rtl/ff256_pow_engine.sv | 105 ++++++++++
 tb/tb_ff256_pow_engine.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ff256_pow_engine_if.sv
// ff256_pow_engine_if: Wishbone slave bus bundle for the GF(256) power engine.
//   adr_i  word address        data_i write data      data_o read data
//   we_i   write enable        sel_i  byte selects    stb_i  strobe
//   cyc_i  cycle valid         ack_o  acknowledge
interface ff256_pow_engine_if #(
  parameter int BUS_WIDTH  = 1,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4
);
  logic [BUS_WIDTH-1:0]  adr_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  we_i;
  logic [BE_WIDTH-1:0]   sel_i;
  logic                  stb_i;
  logic                  cyc_i;
  logic                  ack_o;
  modport master (
    output adr_i, data_i, we_i, sel_i, stb_i, cyc_i,
    input  data_o, ack_o
  );
  modport slave (
    input  adr_i, data_i, we_i, sel_i, stb_i, cyc_i,
    output data_o, ack_o
  );
endinterface

// File: rtl/ff256_pow_engine.sv
// ff256_pow_engine: Wishbone slave computing a^e and a^-1 (= a^254) in GF(2^8).
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    Wishbone slave: addr 0 CFG {INV, EXP, BASE}, addr 1 CTRL/STAT
//          (write bit0 START, bit1 CLR_DONE; read {ERR, DONE, BUSY, RESULT})
module ff256_pow_engine #(
  parameter int         BUS_WIDTH  = 1,
  parameter int         DATA_WIDTH = 32,
  parameter int         BE_WIDTH   = 4,
  parameter logic [8:0] POLY       = 9'h11B
) (
  input logic               clk,
  input logic               reset,
  ff256_pow_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t                state_q;
  logic [7:0]            base_q, exp_q, result_q, a_q, e_q, acc_q, acc_d, sq;
  logic                  inv_q, inv_run_q, busy_q, done_q, err_q;
  logic [2:0]            i_q;
  logic [BUS_WIDTH-1:0]  adr;
  logic [BE_WIDTH-1:0]   sel;
  logic [DATA_WIDTH-1:0] wdat;
  logic                  wr, cfg_wr, ctl_wr, start, clr, unused;

  // Carry-less 8x8 product folded back into the field from the top bit down.
  function automatic logic [7:0] gfmul(input logic [7:0] x, input logic [7:0] y);
    logic [14:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) p ^= y[k] ? {7'd0, x} << k : 15'd0;
    for (int k = 14; k >= 8; k--) p ^= p[k] ? {6'd0, POLY} << (k - 8) : 15'd0;
    return p[7:0];
  endfunction

  assign adr    = bus.adr_i;
  assign sel    = bus.sel_i;
  assign wdat   = bus.data_i;
  assign wr     = bus.stb_i & bus.cyc_i & bus.we_i;
  assign cfg_wr = wr & ~adr[0] & ~busy_q;
  assign ctl_wr = wr & adr[0] & sel[0];
  assign start  = ctl_wr & wdat[0];
  assign clr    = ctl_wr & wdat[1];
  assign unused = ^{wdat, adr, sel};

  // One MSB-first square-and-multiply step per RUN cycle.
  assign sq    = gfmul(acc_q, acc_q);
  assign acc_d = e_q[i_q] ? gfmul(sq, a_q) : sq;

  assign bus.ack_o  = bus.stb_i & bus.cyc_i;
  assign bus.data_o = adr[0] ? DATA_WIDTH'({err_q, done_q, busy_q, result_q})
                             : DATA_WIDTH'({inv_q, exp_q, base_q});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      exp_q     <= '0;
      inv_q     <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      a_q       <= '0;
      e_q       <= '0;
      acc_q     <= '0;
      inv_run_q <= 1'b0;
      i_q       <= 3'd7;
    end else begin
      if (cfg_wr & sel[0]) base_q <= wdat[7:0];
      if (cfg_wr & sel[1]) exp_q <= wdat[15:8];
      if (cfg_wr & sel[2]) inv_q <= wdat[16];
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q       <= base_q;
            e_q       <= inv_q ? 8'hFE : exp_q;
            inv_run_q <= inv_q;
            acc_q     <= 8'h01;
            i_q       <= 3'd7;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end else if (clr) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (i_q == 3'd0) state_q <= FIN;
          else i_q <= i_q - 3'd1;
        end
        FIN: begin
          result_q <= acc_q;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          err_q    <= inv_run_q & (a_q == 8'h00);
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ff256_pow_engine.sv
// tb_ff256_pow_engine: scoreboard bench for the GF(256) power engine.
module tb_ff256_pow_engine;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc_cnt = 0;
  int   t0 = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [31:0] d;
  typedef struct {logic [7:0] res; logic err;} exp_t;
  exp_t sb[$];

  ff256_pow_engine_if bus();
  ff256_pow_engine dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] m_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) r ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] m_pow(input logic [7:0] x, input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 0; k < e; k++) r = m_mul(r, x);
    return r;
  endfunction

  task automatic wb_wr(input logic adr, input logic [31:0] dat, input logic [3:0] s);
    @(negedge clk);
    bus.adr_i = adr; bus.data_i = dat; bus.sel_i = s;
    bus.we_i = 1'b1; bus.stb_i = 1'b1; bus.cyc_i = 1'b1;
    @(posedge clk); #1;
    bus.we_i = 1'b0; bus.stb_i = 1'b0; bus.cyc_i = 1'b0;
  endtask

  task automatic wb_rd(input logic adr, output logic [31:0] dat);
    @(negedge clk);
    bus.adr_i = adr; bus.we_i = 1'b0; bus.stb_i = 1'b1; bus.cyc_i = 1'b1;
    #1;
    dat = bus.data_o;
    chk("ack_rd", {31'd0, bus.ack_o}, 32'd1);
    bus.stb_i = 1'b0; bus.cyc_i = 1'b0;
  endtask

  task automatic start_op(input logic [7:0] b, input logic [7:0] e, input logic inv,
                          input logic [7:0] res, input logic err);
    wb_wr(1'b0, {15'd0, inv, e, b}, 4'b0111);
    sb.push_back('{res, err});
    wb_wr(1'b1, 32'd1, 4'b0001);
    t0 = cyc_cnt;
  endtask

  task automatic finish_op(input string tag);
    int n;
    exp_t x;
    n = 0;
    bus.adr_i = 1'b1;
    #1;
    while (bus.data_o[8] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_busy_end"}, {31'd0, bus.data_o[8]}, 32'd0);
    chk({tag, "_latency"}, cyc_cnt - t0, 32'd9);
    wb_rd(1'b1, d);
    x = sb.pop_front();
    chk({tag, "_result"}, {24'd0, d[7:0]}, {24'd0, x.res});
    chk({tag, "_done"}, {31'd0, d[9]}, 32'd1);
    chk({tag, "_err"}, {31'd0, d[10]}, {31'd0, x.err});
  endtask

  initial begin
    bus.adr_i = '0; bus.data_i = '0; bus.we_i = 1'b0;
    bus.sel_i = '0; bus.stb_i = 1'b0; bus.cyc_i = 1'b0;
    repeat (3) @(posedge clk);
    wb_rd(1'b0, d); chk("rst_cfg", d, 32'd0);
    wb_rd(1'b1, d); chk("rst_stat", d, 32'd0);
    @(negedge clk) reset = 1'b1;

    start_op(8'h02, 8'h08, 1'b0, 8'h1B, 1'b0); finish_op("pow_2_8");
    start_op(8'h02, 8'h07, 1'b0, 8'h80, 1'b0); finish_op("pow_2_7");
    start_op(8'h53, 8'h00, 1'b1, 8'hCA, 1'b0); finish_op("inv_53");
    start_op(8'hCA, 8'h00, 1'b1, 8'h53, 1'b0); finish_op("inv_ca");
    start_op(8'h03, 8'hFF, 1'b0, 8'h01, 1'b0); finish_op("gen_order");
    start_op(8'h00, 8'h00, 1'b0, 8'h01, 1'b0); finish_op("zero_pow_zero");
    start_op(8'h00, 8'h05, 1'b0, 8'h00, 1'b0); finish_op("zero_pow_5");
    start_op(8'h00, 8'h00, 1'b1, 8'h00, 1'b1); finish_op("inv_zero");
    wb_wr(1'b1, 32'd2, 4'b0001);
    wb_rd(1'b1, d); chk("clr_done", d, 32'd0);

    for (int k = 0; k < 6; k++) begin
      logic [7:0] b, e;
      logic inv;
      b = 8'($urandom_range(0, 255));
      e = 8'($urandom_range(0, 255));
      inv = 1'($urandom_range(0, 1));
      start_op(b, e, inv, inv ? m_pow(b, 254) : m_pow(b, int'(e)), inv && b == 8'h00);
      finish_op("rand");
    end

    start_op(8'h02, 8'h08, 1'b0, 8'h1B, 1'b0);
    wb_wr(1'b1, 32'd1, 4'b0001);
    wb_wr(1'b0, 32'h00FF_FFFF, 4'b1111);
    finish_op("start_in_busy");
    wb_rd(1'b0, d); chk("cfg_in_busy", d, 32'h0000_0802);

    wb_wr(1'b0, 32'h0001_5577, 4'b0010);
    wb_rd(1'b0, d); chk("sel_exp_only", d, 32'h0000_5502);

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.stb_i = k[0]; bus.cyc_i = k[1];
      #1;
      chk("ack_comb", {31'd0, bus.ack_o}, {31'd0, k[0] & k[1]});
    end
    bus.stb_i = 1'b0; bus.cyc_i = 1'b0;

    wb_wr(1'b0, 32'h0000_0502, 4'b0111);
    wb_wr(1'b1, 32'd1, 4'b0001);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    wb_rd(1'b0, d); chk("midrun_rst_cfg", d, 32'd0);
    wb_rd(1'b1, d); chk("midrun_rst_stat", d, 32'd0);
    @(negedge clk) reset = 1'b1;
    start_op(8'h03, 8'h02, 1'b0, 8'h05, 1'b0); finish_op("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
